// File: rtl/enemy_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | enemy_pkg : shared states, slot constants, slot picker           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package enemy_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GAP      = 3'd1,
    ACTIVE   = 3'd2,
    HIT_SHOW = 3'd3,
    OVER     = 3'd4
  } state_t;

  localparam logic [3:0] POS_NONE = 4'd0;
  localparam logic [3:0] POS_Q    = 4'd1;
  localparam logic [3:0] POS_W    = 4'd2;
  localparam logic [3:0] POS_E    = 4'd3;
  localparam logic [3:0] POS_A    = 4'd4;
  localparam logic [3:0] POS_S    = 4'd5;
  localparam logic [3:0] POS_D    = 4'd6;
  localparam logic [3:0] POS_Z    = 4'd7;
  localparam logic [3:0] POS_X    = 4'd8;
  localparam logic [3:0] POS_C    = 4'd9;

  // Maps the random byte onto slots 1-9, stepping past the previous slot.
  function automatic logic [3:0] pick_pos(input logic [7:0] rnd, input logic [3:0] last);
    logic [3:0] cand;
    cand = 4'(rnd % 8'd9) + 4'd1;
    if (cand == last) cand = (cand == POS_C) ? POS_Q : cand + 4'd1;
    return cand;
  endfunction

endpackage
`default_nettype wire

// File: rtl/game_lfsr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | game_lfsr : 8-bit Fibonacci LFSR, taps 8,6,5,4                   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module game_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) r_q <= SEED;
    else     r_q <= {r_q[6:0], r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]};
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/enemy_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | enemy_scheduler : whack-a-mole enemy timing, scoring and lives   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module enemy_scheduler
  import enemy_pkg::*;
#(
  parameter int unsigned LIFE_TICKS = 8,
  parameter int unsigned GAP_TICKS  = 2,
  parameter int unsigned HIT_TICKS  = 2,
  parameter int unsigned LIVES_INIT = 3,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key_pos,
  output logic [3:0] pos,
  output logic       hit,
  output logic       damage,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [3:0] c_gap_last  = 4'(GAP_TICKS - 1);
  localparam logic [3:0] c_life_last = 4'(LIFE_TICKS - 1);
  localparam logic [3:0] c_hit_last  = 4'(HIT_TICKS - 1);
  localparam logic [1:0] c_lives     = 2'(LIVES_INIT);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_pos, w_pos_nxt;
  logic [3:0] r_last, w_last_nxt;
  logic [7:0] r_score, w_score_nxt;
  logic [1:0] r_lives, w_lives_nxt;
  logic       r_damage, w_damage_nxt;
  logic       r_hit, r_over;
  logic [7:0] w_lfsr;

  game_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_pos    <= POS_NONE;
      r_last   <= POS_NONE;
      r_score  <= 8'd0;
      r_lives  <= c_lives;
      r_damage <= 1'b0;
      r_hit    <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pos    <= w_pos_nxt;
      r_last   <= w_last_nxt;
      r_score  <= w_score_nxt;
      r_lives  <= w_lives_nxt;
      r_damage <= w_damage_nxt;
      r_hit    <= (w_state_nxt == HIT_SHOW);
      r_over   <= (w_state_nxt == OVER);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pos_nxt    = r_pos;
    w_last_nxt   = r_last;
    w_score_nxt  = r_score;
    w_lives_nxt  = r_lives;
    w_damage_nxt = 1'b0;
    case (r_state)
      IDLE, OVER: begin
        if (start) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = 4'd0;
          w_pos_nxt   = POS_NONE;
          w_last_nxt  = POS_NONE;
          w_score_nxt = 8'd0;
          w_lives_nxt = c_lives;
        end
      end
      GAP: begin
        if (tick) begin
          if (r_cnt == c_gap_last) begin
            w_pos_nxt   = pick_pos(w_lfsr, r_last);
            w_last_nxt  = w_pos_nxt;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ACTIVE;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      ACTIVE: begin
        // A hit wins over an expiring tick in the same cycle.
        if (key_valid && (key_pos == r_pos)) begin
          w_state_nxt = HIT_SHOW;
          w_cnt_nxt   = 4'd0;
          if (r_score != 8'hFF) w_score_nxt = r_score + 8'd1;
        end else if (tick) begin
          if (r_cnt == c_life_last) begin
            w_damage_nxt = 1'b1;
            w_lives_nxt  = r_lives - 2'd1;
            w_pos_nxt    = POS_NONE;
            w_cnt_nxt    = 4'd0;
            w_state_nxt  = (r_lives == 2'd1) ? OVER : GAP;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      HIT_SHOW: begin
        if (tick) begin
          if (r_cnt == c_hit_last) begin
            w_pos_nxt   = POS_NONE;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = GAP;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pos_nxt   = POS_NONE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign pos       = r_pos;
  assign hit       = r_hit;
  assign damage    = r_damage;
  assign score     = r_score;
  assign lives     = r_lives;
  assign game_over = r_over;

endmodule
`default_nettype wire

// File: doc/enemy_scheduler.md
ENEMY_SCHEDULER -- requirements
Module: enemy_scheduler

Interface
REQ-001 Parameter LIFE_TICKS, default 8: ticks an enemy stays up before it counts as a miss (range 1-15).
REQ-002 Parameter GAP_TICKS, default 2: ticks with no enemy between appearances (range 1-15).
REQ-003 Parameter HIT_TICKS, default 2: ticks the hit indication is held after a successful hit (range 1-15).
REQ-004 Parameter LIVES_INIT, default 3: lives at game start (range 1-3).
REQ-005 Parameter LFSR_SEED, default 8'hA5: nonzero LFSR reset value.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  one-cycle request to begin a game; honoured only in IDLE or OVER.
REQ-009 tick  input  1  one-cycle game-time strobe; all timing is counted in ticks.
REQ-010 key_valid  input  1  one-cycle strobe for a player key press.
REQ-011 key_pos  input  4  pressed position (1-9 = Q,W,E,A,S,D,Z,X,C); sampled only when key_valid=1.
REQ-012 pos  output  4  enemy position to the sprite renderer (0 = none, 1-9 = slot).
REQ-013 hit  output  1  high throughout HIT_SHOW.
REQ-014 damage  output  1  one-cycle pulse on each missed enemy.
REQ-015 score  output  8  hit count, saturating at 255.
REQ-016 lives  output  2  remaining lives.
REQ-017 game_over  output  1  high in OVER.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, GAP, ACTIVE, HIT_SHOW and OVER.
REQ-019 The block SHALL advance an 8-bit Fibonacci LFSR (taps 8,6,5,4) every cycle, reset or not excepted.
REQ-020 Candidate position SHALL be (lfsr mod 9)+1; if it equals the last shown position, the block SHALL use (candidate mod 9)+1 instead, so no slot repeats back-to-back.
REQ-021 IDLE: pos=0; start SHALL load score=0 and lives=LIVES_INIT, clear last position and enter GAP.
REQ-022 GAP: pos=0; on the GAP_TICKS-th tick the block SHALL latch the candidate into pos, clear the tick counter and enter ACTIVE on the next cycle.
REQ-023 ACTIVE: key_valid with key_pos==pos SHALL enter HIT_SHOW, increment score (saturating) and clear the tick counter; wrong keys SHALL be ignored.
REQ-024 ACTIVE: on the LIFE_TICKS-th tick without a hit, the block SHALL pulse damage for one cycle, decrement lives, and enter OVER if lives was 1, else GAP.
REQ-025 A matching key and the expiring tick in the same cycle SHALL count as a hit: no damage, no life lost.
REQ-026 HIT_SHOW: pos SHALL hold and hit=1; on the HIT_TICKS-th tick the block SHALL enter GAP with pos=0.
REQ-027 OVER: pos=0 and game_over=1; score SHALL hold; start SHALL restart as in REQ-021.
REQ-028 start outside IDLE/OVER and key_valid outside ACTIVE SHALL have no effect.
REQ-029 All outputs SHALL be registered; pos, hit and game_over SHALL change in the cycle after the triggering event.

Reset
REQ-030 rst=1 SHALL force state IDLE, pos=0, hit=0, damage=0, score=0, lives=LIVES_INIT, game_over=0, tick counter=0, lfsr=LFSR_SEED.
REQ-031 Reset asserted in any state, including during a damage pulse, SHALL take priority over all other inputs in that cycle.

Structure
REQ-032 Shared package enemy_pkg SHALL hold the state enumeration and the position constants POS_NONE=0, POS_Q=1 through POS_C=9.
REQ-033 The LFSR SHALL be a sub-module named game_lfsr (ports clk, rst, q[7:0]; parameter SEED).
REQ-034 The tick counter SHALL be 4 bits wide and shared by GAP, ACTIVE and HIT_SHOW.

Verification
REQ-035 Reset then start, tick every 4 cycles -> pos=0 through 2 ticks, then pos in 1-9, lives=3, score=0.
REQ-036 In ACTIVE, key_valid with key_pos==pos -> hit=1 for 2 ticks, score=1, damage never pulses, then GAP.
REQ-037 No keys from start -> 3 damage pulses, each 8 ticks after its enemy appears; lives 3->2->1->0, game_over=1 after the third.
REQ-038 Matching key coincident with the 8th ACTIVE tick -> score increments, lives unchanged, no damage.
REQ-039 1000 appearances with score forced near 255 -> no consecutive identical pos; score saturates at 255.
REQ-040 rst mid-ACTIVE with score=5 -> next cycle pos=0, score=0, state IDLE; start in OVER -> new game with lives=3.
